// File: rtl/ex_mem_skid.sv
// Two-entry elastic buffer between execute and memory stages. The head entry is
// also exposed for forwarding; acceptance stops once a halt entry is taken.
module ex_mem_skid #(
  parameter int unsigned W  = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_result,
  input  logic [W-1:0]  in_sdata,
  input  logic [W-1:0]  in_pc,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  input  logic          in_mrd,
  input  logic          in_mwr,
  input  logic          in_halt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic [W-1:0]  out_sdata,
  output logic [W-1:0]  out_pc,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  output logic          out_mrd,
  output logic          out_mwr,
  output logic          out_halt,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [W-1:0]  fwd_data,
  output logic          halted
);

  localparam int unsigned PW = 3 * W + RW + 4;

  logic [PW-1:0] slot_q [2];
  logic [PW-1:0] in_payload;
  logic [PW-1:0] head;
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          halted_q, halted_d;
  logic          push, pop;

  assign in_payload = {in_result, in_sdata, in_pc, in_rd, in_we, in_mrd, in_mwr, in_halt};

  // flush is the only input allowed to reach in_ready combinationally
  assign in_ready  = (count_q != 2'd2) & ~halted_q & ~flush;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head = slot_q[rd_ptr_q];
  assign {out_result, out_sdata, out_pc, out_rd, out_we, out_mrd, out_mwr, out_halt} = head;

  assign fwd_valid = out_valid & out_we;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;
  assign halted    = halted_q;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    halted_d = halted_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      halted_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
        halted_d = halted_q | in_halt;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      halted_q <= halted_d;
    end
  end

  // Slot contents survive flush; only pointers and count are squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (push) begin
      slot_q[wr_ptr_q] <= in_payload;
    end
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: a queue model of buffered entries predicts
// in_ready, the head payload and the halt flag every cycle.
module tb_ex_mem_skid;

  localparam int unsigned W  = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned PW = 3 * W + RW + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_result = '0;
  logic [W-1:0]  in_sdata = '0;
  logic [W-1:0]  in_pc = '0;
  logic [RW-1:0] in_rd = '0;
  logic          in_we = 1'b0;
  logic          in_mrd = 1'b0;
  logic          in_mwr = 1'b0;
  logic          in_halt = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result, out_sdata, out_pc;
  logic [RW-1:0] out_rd;
  logic          out_we, out_mrd, out_mwr, out_halt;
  logic          fwd_valid;
  logic [RW-1:0] fwd_rd;
  logic [W-1:0]  fwd_data;
  logic          halted;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [PW-1:0] sb [$];
  logic          m_halted = 1'b0;

  ex_mem_skid #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_sdata(in_sdata), .in_pc(in_pc), .in_rd(in_rd),
    .in_we(in_we), .in_mrd(in_mrd), .in_mwr(in_mwr), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_sdata(out_sdata), .out_pc(out_pc), .out_rd(out_rd),
    .out_we(out_we), .out_mrd(out_mrd), .out_mwr(out_mwr), .out_halt(out_halt),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one entry; the other payload fields are derived from the result.
  task automatic drive(input logic v, input logic [W-1:0] r, input logic h);
    in_valid  = v;
    in_result = r;
    in_sdata  = r ^ 16'hFFFF;
    in_pc     = r + 16'd2;
    in_rd     = r[2:0];
    in_we     = r[0];
    in_mrd    = r[1];
    in_mwr    = r[2];
    in_halt   = h;
  endtask

  task automatic drive_pc(input logic [W-1:0] r, input logic [W-1:0] pc, input logic h);
    drive(1'b1, r, h);
    in_pc = pc;
  endtask

  // Check current outputs against the model, then advance one clock.
  task automatic cycle();
    logic          exp_ready;
    logic          do_push, do_pop;
    logic [PW-1:0] got, entry;
    #1;
    exp_ready = (sb.size() != 2) && !m_halted && !flush;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("halted", 64'(halted), 64'(m_halted));
    if (sb.size() != 0) begin
      got = {out_result, out_sdata, out_pc, out_rd, out_we, out_mrd, out_mwr, out_halt};
      check("head_payload", 64'(got), 64'(sb[0]));
      check("fwd_valid", 64'(fwd_valid), 64'(sb[0][3]));
      check("fwd_data", 64'(fwd_data), 64'(sb[0][PW-1 -: W]));
    end else begin
      check("fwd_valid_empty", 64'(fwd_valid), 64'd0);
    end
    do_push = in_valid && exp_ready;
    do_pop  = (sb.size() != 0) && out_ready;
    entry   = {in_result, in_sdata, in_pc, in_rd, in_we, in_mrd, in_mwr, in_halt};
    @(posedge clk);
    if (flush) begin
      sb.delete();
      m_halted = 1'b0;
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back(entry);
        if (entry[0]) m_halted = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(out_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b0);
      cycle();
    end
    drain();

    // Backpressure until full, then release
    out_ready = 1'b0;
    drive(1'b1, 16'hA5A5, 1'b0);
    cycle();
    drive(1'b1, 16'h5A5A, 1'b0);
    cycle();
    drive(1'b0, 16'h0000, 1'b0);
    cycle();
    check("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    // Simultaneous push/pop at count 1, pointers wrap repeatedly
    out_ready = 1'b0;
    drive(1'b1, 16'h1234, 1'b0);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'hBEEF + W'(i), 1'b0);
      cycle();
    end
    drain();

    // Flush at count 2 with a same-cycle push
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 1'b0);
    cycle();
    drive(1'b1, 16'h2223, 1'b0);
    cycle();
    drive(1'b1, 16'h7777, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    cycle();
    check("flush_fwd_valid", 64'(fwd_valid), 64'd0);
    out_ready = 1'b1;
    cycle();
    cycle();

    // Halt: entry accepted, further pushes refused, halt entry drains
    out_ready = 1'b0;
    drive_pc(16'h0101, 16'h0042, 1'b1);
    cycle();
    drive(1'b1, 16'h3333, 1'b0);
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    check("halt_sticky", 64'(halted), 64'd1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b1, 16'h4444, 1'b0);
    cycle();
    drain();

    // Asynchronous reset mid-stream at count 2
    out_ready = 1'b0;
    drive(1'b1, 16'hCAFE, 1'b0);
    cycle();
    drive(1'b1, 16'hF00D, 1'b0);
    cycle();
    drive(1'b0, 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_payload", 64'({out_result, out_sdata, out_pc, out_rd,
                               out_we, out_mrd, out_mwr, out_halt}), 64'd0);
    check("arst_fwd_valid", 64'(fwd_valid), 64'd0);
    sb.delete();
    m_halted = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h0F0F, 1'b0);
    cycle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
